operand_entry_accumulator: RTL and testbench

//   Builds a 10-bit unsigned operand (0..1023) from decimal key presses on the

---
 rtl/operand_entry_accumulator.sv | 111 +++++++++++
 tb/tb_operand_entry_accumulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_accumulator.sv
// Operand entry accumulator: builds a 10-bit unsigned operand from decimal
// keypad presses. Handles digit, clear, backspace and enter keys.
// Every output is registered and updates on the edge that samples the key.
module operand_entry_accumulator #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_VALUE  = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [9:0] operand,
  output logic       operand_valid,
  output logic [2:0] digit_count,
  output logic       entry_err
);

  localparam int unsigned OP_W  = 10;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned EXT_W = 14;  // wide enough for 1023*10+9 without wrap

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [OP_W-1:0]    operand_q;
  logic [CNT_W-1:0]   digit_count_q;
  logic               entry_err_q;
  logic               operand_valid_q;

  logic [EXT_W-1:0]   next_val;
  logic               is_digit;
  logic               digit_ok;

  // Candidate value after appending the digit, and whether it is acceptable
  always_comb begin
    next_val = EXT_W'(operand_q) * EXT_W'(10) + EXT_W'(key_code);
    is_digit = (key_code <= 4'd9);
    digit_ok = (next_val <= EXT_W'(MAX_VALUE)) &&
               (digit_count_q < CNT_W'(MAX_DIGITS));
  end

  // Entry FSM with registered outputs; reset drops any simultaneous key
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      operand_q       <= '0;
      digit_count_q   <= '0;
      entry_err_q     <= 1'b0;
      operand_valid_q <= 1'b0;
    end else begin
      operand_valid_q <= 1'b0;
      if (key_valid) begin
        if (is_digit) begin
          if (state_q == S_DONE) begin
            // A digit after delivery starts a fresh operand
            operand_q     <= OP_W'(key_code);
            digit_count_q <= CNT_W'(1);
            entry_err_q   <= 1'b0;
            state_q       <= S_ENTRY;
          end else if (digit_ok) begin
            operand_q     <= next_val[OP_W-1:0];
            digit_count_q <= digit_count_q + CNT_W'(1);
            state_q       <= S_ENTRY;
          end else begin
            entry_err_q   <= 1'b1;
          end
        end else begin
          case (key_code)
            KEY_CLEAR: begin
              operand_q     <= '0;
              digit_count_q <= '0;
              entry_err_q   <= 1'b0;
              state_q       <= S_IDLE;
            end
            KEY_BKSP: begin
              if (state_q == S_ENTRY) begin
                operand_q     <= operand_q / OP_W'(10);
                digit_count_q <= digit_count_q - CNT_W'(1);
                entry_err_q   <= 1'b0;
                if (digit_count_q == CNT_W'(1)) begin
                  state_q <= S_IDLE;
                end
              end
            end
            KEY_ENTER: begin
              if (state_q == S_ENTRY) begin
                state_q         <= S_DONE;
                operand_valid_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign operand       = operand_q;
  assign operand_valid = operand_valid_q;
  assign digit_count   = digit_count_q;
  assign entry_err     = entry_err_q;

endmodule

// File: tb/tb_operand_entry_accumulator.sv
// Directed bench for operand_entry_accumulator: each step pushes its expected
// outputs to a scoreboard queue, then pops and compares after the sampling edge.
module tb_operand_entry_accumulator;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [9:0] operand;
  logic       operand_valid;
  logic [2:0] digit_count;
  logic       entry_err;

  typedef struct packed {
    logic [9:0] op;
    logic [2:0] cnt;
    logic       err;
    logic       vld;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_BSP = 4'hB;
  localparam logic [3:0] K_ENT = 4'hC;

  operand_entry_accumulator #(
    .MAX_DIGITS(4),
    .MAX_VALUE (1023)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .operand      (operand),
    .operand_valid(operand_valid),
    .digit_count  (digit_count),
    .entry_err    (entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare_next(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty: got op=%0d expected an entry", tag, operand);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert (operand === e.op) else begin
        errors++;
        $error("FAIL %s operand: got %0d expected %0d", tag, operand, e.op);
      end
      checks++;
      assert (digit_count === e.cnt) else begin
        errors++;
        $error("FAIL %s digit_count: got %0d expected %0d", tag, digit_count, e.cnt);
      end
      checks++;
      assert (entry_err === e.err) else begin
        errors++;
        $error("FAIL %s entry_err: got %b expected %b", tag, entry_err, e.err);
      end
      checks++;
      assert (operand_valid === e.vld) else begin
        errors++;
        $error("FAIL %s operand_valid: got %b expected %b", tag, operand_valid, e.vld);
      end
    end
  endtask

  // Drive one key for one cycle, with the outputs expected after that edge
  task automatic press(input logic [3:0] code, input logic [9:0] op,
                       input logic [2:0] cnt, input logic err, input logic vld,
                       input string tag);
    exp_t e;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    e = '{op: op, cnt: cnt, err: err, vld: vld};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    compare_next(tag);
  endtask

  // One cycle with no key
  task automatic idle(input logic [9:0] op, input logic [2:0] cnt,
                      input logic err, input string tag);
    exp_t e;
    @(negedge clk);
    key_valid = 1'b0;
    e = '{op: op, cnt: cnt, err: err, vld: 1'b0};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_next(tag);
  endtask

  initial begin
    exp_t e;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;

    // Reset held for two cycles
    @(posedge clk);
    @(posedge clk);
    #1;
    e = '{op: 10'd0, cnt: 3'd0, err: 1'b0, vld: 1'b0};
    sb_q.push_back(e);
    compare_next("reset");
    @(negedge clk);
    reset = 1'b0;

    // 8,7,0,enter -> 870 with a single pulse
    press(4'd8,  10'd8,   3'd1, 1'b0, 1'b0, "d8");
    press(4'd7,  10'd87,  3'd2, 1'b0, 1'b0, "d87");
    press(4'd0,  10'd870, 3'd3, 1'b0, 1'b0, "d870");
    press(K_ENT, 10'd870, 3'd3, 1'b0, 1'b1, "enter870");
    idle(10'd870, 3'd3, 1'b0, "after870");

    // 1,0,2,3,enter -> 1023 (max value, max digits)
    press(4'd1,  10'd1,    3'd1, 1'b0, 1'b0, "new1");
    press(4'd0,  10'd10,   3'd2, 1'b0, 1'b0, "d10");
    press(4'd2,  10'd102,  3'd3, 1'b0, 1'b0, "d102");
    press(4'd3,  10'd1023, 3'd4, 1'b0, 1'b0, "d1023");
    press(K_ENT, 10'd1023, 3'd4, 1'b0, 1'b1, "enter1023");
    idle(10'd1023, 3'd4, 1'b0, "after1023");

    // 1,0,2,4 -> overflow rejected
    press(4'd1, 10'd1,   3'd1, 1'b0, 1'b0, "ov1");
    press(4'd0, 10'd10,  3'd2, 1'b0, 1'b0, "ov10");
    press(4'd2, 10'd102, 3'd3, 1'b0, 1'b0, "ov102");
    press(4'd4, 10'd102, 3'd3, 1'b1, 1'b0, "ov_reject");
    // Accepted digit keeps the sticky error; fifth digit rejected by count
    press(4'd3,  10'd1023, 3'd4, 1'b1, 1'b0, "sticky1023");
    press(4'd0,  10'd1023, 3'd4, 1'b1, 1'b0, "count_reject");
    press(K_ENT, 10'd1023, 3'd4, 1'b1, 1'b1, "enter_keeps_err");
    press(4'hE,  10'd1023, 3'd4, 1'b1, 1'b0, "unused_code");
    press(K_BSP, 10'd1023, 3'd4, 1'b1, 1'b0, "bksp_in_done");

    // 5,1,2,backspace,clear
    press(4'd5,  10'd5,   3'd1, 1'b0, 1'b0, "d5");
    press(4'd1,  10'd51,  3'd2, 1'b0, 1'b0, "d51");
    press(4'd2,  10'd512, 3'd3, 1'b0, 1'b0, "d512");
    press(K_BSP, 10'd51,  3'd2, 1'b0, 1'b0, "bksp51");
    press(K_CLR, 10'd0,   3'd0, 1'b0, 1'b0, "clear");
    press(K_ENT, 10'd0,   3'd0, 1'b0, 1'b0, "enter_in_idle");
    press(K_BSP, 10'd0,   3'd0, 1'b0, 1'b0, "bksp_in_idle");

    // Leading zero enters ENTRY; backspace back to IDLE
    press(4'd0,  10'd0, 3'd1, 1'b0, 1'b0, "lead_zero");
    press(K_BSP, 10'd0, 3'd0, 1'b0, 1'b0, "bksp_to_idle");
    press(K_ENT, 10'd0, 3'd0, 1'b0, 1'b0, "enter_idle_again");

    // 9,enter,enter,4 -> one pulse only
    press(4'd9,  10'd9, 3'd1, 1'b0, 1'b0, "d9");
    press(K_ENT, 10'd9, 3'd1, 1'b0, 1'b1, "enter9");
    press(K_ENT, 10'd9, 3'd1, 1'b0, 1'b0, "enter9_repeat");
    press(4'd4,  10'd4, 3'd1, 1'b0, 1'b0, "new4");

    // 3,3 then reset together with key 7
    press(K_CLR, 10'd0,  3'd0, 1'b0, 1'b0, "clear2");
    press(4'd3,  10'd3,  3'd1, 1'b0, 1'b0, "d3");
    press(4'd3,  10'd33, 3'd2, 1'b0, 1'b0, "d33");
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd7;
    e = '{op: 10'd0, cnt: 3'd0, err: 1'b0, vld: 1'b0};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    compare_next("reset_drops_key");
    @(negedge clk);
    reset = 1'b0;
    idle(10'd0, 3'd0, 1'b0, "post_reset");
    press(4'd5, 10'd5, 3'd1, 1'b0, 1'b0, "after_reset_digit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
